// File: rtl/sha_msg_sched.sv
// SHA-256 message-schedule window: loads one 512-bit block, shifts in W_{t+16} per round for ROUNDS rounds.
// Define SHA_SCHED_INTERNAL_EN to compute the next schedule word internally instead of taking i_new_word.
module sha_msg_sched #(
    parameter int ROUNDS = 64,
    parameter int WORD_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_blk_valid,
    output logic              o_blk_ready,
    input  logic [511:0]      i_blk,
    input  logic              i_adv,
    input  logic [WORD_W-1:0] i_new_word,
    output logic [511:0]      o_words,
    output logic [31:0]       o_wt,
    output logic [5:0]        o_round,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [511:0] words_q, words_d;
    logic [5:0]   round_q, round_d;
    logic [31:0]  fill_word;

`ifdef SHA_SCHED_INTERNAL_EN
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Operands: slot 1 = W_{t+14}, slot 6 = W_{t+9}, slot 14 = W_{t+1}, slot 15 = W_t
    assign fill_word = sigma1(words_q[63:32]) + words_q[223:192]
                     + sigma0(words_q[479:448]) + words_q[511:480];

    logic unused_new_word;
    assign unused_new_word = ^i_new_word;
`else
    assign fill_word = i_new_word;
`endif

    always_comb begin
        state_d = state_q;
        words_d = words_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (i_blk_valid) begin
                    words_d = i_blk;
                    round_d = 6'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (i_adv) begin
                    // Slot k takes slot k-1; the new word enters at slot 0
                    words_d = {words_q[479:0], fill_word};
                    if (round_q == 6'(ROUNDS - 1)) begin
                        state_d = DONE;
                    end else begin
                        round_d = round_q + 6'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            words_q <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            round_q <= round_d;
        end
    end

    assign o_words     = words_q;
    assign o_wt        = words_q[511:480];
    assign o_round     = round_q;
    assign o_blk_ready = (state_q == IDLE);
    assign o_busy      = (state_q == RUN);
    assign o_done      = (state_q == DONE);

endmodule

// File: tb/tb_sha_msg_sched.sv
// Self-checking bench for sha_msg_sched: schedule-array model plus literal checks from hand-computed SHA-256 values.
// Works in both builds; the external-word pattern test runs only without SHA_SCHED_INTERNAL_EN.
module tb_sha_msg_sched;

    localparam int ROUNDS = 64;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_blk_valid = 1'b0;
    logic         o_blk_ready;
    logic [511:0] i_blk = '0;
    logic         i_adv = 1'b0;
    logic [31:0]  i_new_word = '0;
    logic [511:0] o_words;
    logic [31:0]  o_wt;
    logic [5:0]   o_round;
    logic         o_busy;
    logic         o_done;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    // Model: the whole schedule W[0..79], number of advances taken, and phase 0=idle 1=run 2=done
    logic [31:0] w_m [0:79];
    int          adv_m = 0;
    int          phase_m = 0;

    logic [511:0] abc_blk;

    sha_msg_sched #(.ROUNDS(ROUNDS), .WORD_W(32)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_blk_valid (i_blk_valid),
        .o_blk_ready (o_blk_ready),
        .i_blk       (i_blk),
        .i_adv       (i_adv),
        .i_new_word  (i_new_word),
        .o_words     (o_words),
        .o_wt        (o_wt),
        .o_round     (o_round),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sched_word(input int t);
        logic [31:0] s0, s1;
        s0 = ror(w_m[t+1], 7) ^ ror(w_m[t+1], 18) ^ (w_m[t+1] >> 3);
        s1 = ror(w_m[t+14], 17) ^ ror(w_m[t+14], 19) ^ (w_m[t+14] >> 10);
        return s1 + w_m[t+9] + s0 + w_m[t];
    endfunction

    function automatic logic [511:0] exp_window();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[32*k +: 32] = w_m[adv_m + 15 - k];
        return r;
    endfunction

    function automatic int exp_round();
        return (adv_m > ROUNDS - 1) ? ROUNDS - 1 : adv_m;
    endfunction

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model update on each rising edge using the inputs driven for that edge
    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int j = 0; j < 80; j++) w_m[j] = '0;
            adv_m = 0;
            phase_m = 0;
        end else begin
            case (phase_m)
                0: if (i_blk_valid) begin
                    for (int j = 0; j < 80; j++) w_m[j] = '0;
                    for (int j = 0; j < 16; j++) w_m[j] = i_blk[511 - 32*j -: 32];
                    adv_m = 0;
                    phase_m = 1;
                end
                1: if (i_adv) begin
`ifdef SHA_SCHED_INTERNAL_EN
                    w_m[adv_m + 16] = sched_word(adv_m);
`else
                    w_m[adv_m + 16] = i_new_word;
`endif
                    if (adv_m == ROUNDS - 1) phase_m = 2;
                    adv_m++;
                end
                default: phase_m = 0;
            endcase
        end
    end

    // Every-cycle comparison against the model
    always @(negedge i_clk) begin
        if (check_en) begin
            checkOutput("words", o_words, exp_window());
            checkOutput("wt", 512'(o_wt), 512'(w_m[adv_m]));
            checkOutput("round", 512'(o_round), 512'(exp_round()));
            checkOutput("busy", 512'(o_busy), 512'(phase_m == 1));
            checkOutput("done", 512'(o_done), 512'(phase_m == 2));
            checkOutput("ready", 512'(o_blk_ready), 512'(phase_m == 0));
        end
    end

    task automatic applyStimulus(input logic rst_n, input logic valid, input logic [511:0] blk,
                                 input logic adv, input logic use_ext, input logic [31:0] ext_word);
        @(posedge i_clk);
        #1;
        i_rst_n     = rst_n;
        i_blk_valid = valid;
        i_blk       = blk;
        i_adv       = adv;
        if (use_ext) i_new_word = ext_word;
        else if (phase_m == 1 && adv_m < ROUNDS) i_new_word = sched_word(adv_m);
        else i_new_word = '0;
    endtask

    initial begin
        int cyc;
        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;

        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        check_en = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge i_clk);
        checkOutput("rst_ready", 512'(o_blk_ready), 512'(1));
        checkOutput("rst_words", o_words, '0);
        checkOutput("rst_round", 512'(o_round), 512'(0));
        checkOutput("rst_busy", 512'(o_busy), 512'(0));
        checkOutput("rst_done", 512'(o_done), 512'(0));

        // Load the "abc" block; adv held high alongside the load must be ignored
        applyStimulus(1'b1, 1'b1, abc_blk, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge i_clk);
        checkOutput("abc_wt", 512'(o_wt), 512'(32'h61626380));
        checkOutput("abc_slot0", 512'(o_words[31:0]), 512'(32'h00000018));
        checkOutput("abc_round", 512'(o_round), 512'(0));
        checkOutput("abc_busy", 512'(o_busy), 512'(1));
        checkOutput("abc_ready", 512'(o_blk_ready), 512'(0));

        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge i_clk);
        checkOutput("w16_slot1", 512'(o_words[63:32]), 512'(32'h61626380));
        checkOutput("w17_slot0", 512'(o_words[31:0]), 512'(32'h000F0000));
        checkOutput("w2_wt", 512'(o_wt), 512'(32'h00000000));
        checkOutput("adv2_round", 512'(o_round), 512'(2));

        // Full run with adv stalled every other cycle
        cyc = 0;
        while (phase_m == 1 && cyc < 300) begin
            applyStimulus(1'b1, 1'b0, '0, (cyc % 2) == 0, 1'b0, '0);
            cyc++;
        end
        checkOutput("run_bound", 512'(phase_m), 512'(2));
        i_adv = 1'b1;
        @(negedge i_clk);
        checkOutput("done_pulse", 512'(o_done), 512'(1));
        checkOutput("done_round", 512'(o_round), 512'(63));
        checkOutput("done_busy", 512'(o_busy), 512'(0));
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge i_clk);
        checkOutput("post_ready", 512'(o_blk_ready), 512'(1));
        checkOutput("post_done", 512'(o_done), 512'(0));
        checkOutput("post_round", 512'(o_round), 512'(63));

        // Zero block, then 16 advances of a fixed external word
        applyStimulus(1'b1, 1'b1, '0, 1'b0, 1'b1, 32'hA5A5A5A5);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'hA5A5A5A5);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'hA5A5A5A5);
        @(negedge i_clk);
        checkOutput("ext_round", 512'(o_round), 512'(16));
`ifndef SHA_SCHED_INTERNAL_EN
        checkOutput("ext_words", o_words, {16{32'hA5A5A5A5}});
`endif

        // Reach round 30, then reset with a new block held valid through it
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h3C3C0F0F);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, '0);
        @(negedge i_clk);
        checkOutput("mid_round", 512'(o_round), 512'(30));
        applyStimulus(1'b0, 1'b1, abc_blk, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, abc_blk, 1'b0, 1'b0, '0);
        @(negedge i_clk);
        checkOutput("mrst_words", o_words, '0);
        checkOutput("mrst_round", 512'(o_round), 512'(0));
        checkOutput("mrst_ready", 512'(o_blk_ready), 512'(1));
        checkOutput("mrst_busy", 512'(o_busy), 512'(0));
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge i_clk);
        checkOutput("reload_busy", 512'(o_busy), 512'(1));
        checkOutput("reload_wt", 512'(o_wt), 512'(32'h61626380));
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge i_clk);
        #1;
        check_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sha_msg_sched.md
Name: sha_msg_sched

Overview:
- Message-schedule window for the SHA-256 core.
- Accepts one 512-bit message block over a valid/ready handshake and holds W_t..W_{t+15} in a 16x32 window.
- Presents the window to the round/word adder (slot 15 = current W_t, slots 1/6/14/15 = schedule operands).
- Shifts in the adder's next-word result each round. Runs 64 rounds, then signals done.

Parameters:
ROUNDS, 64, number of round advances per block (must be >=16, <=64)
WORD_W, 32, word width; fixed at 32 for SHA-256, present for lint only

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  synchronous reset, active low
i_blk_valid  in  1  message block present on i_blk
o_blk_ready  out  1  block can be accepted (high only in IDLE)
i_blk  in  512  message block, W0 in [511:480], W15 in [31:0]
i_adv  in  1  round engine consumed W_t; advance one round
i_new_word  in  32  next schedule word W_{t+16} from word adder
o_words  out  512  window; slot k = bits [32k+31:32k] = W_{t+15-k}
o_wt  out  32  current W_t (= slot 15)
o_round  out  6  current round index t
o_busy  out  1  high in RUN
o_done  out  1  one-cycle pulse after final advance

Behaviour:
- FSM states: IDLE, RUN, DONE; all transitions on the rising edge of i_clk.
- IDLE: o_blk_ready=1. On i_blk_valid & o_blk_ready, load window with i_blk directly (slot k <= i_blk[32k+31:32k]), clear o_round to 0, go to RUN. i_adv is ignored.
- RUN: o_blk_ready=0, o_busy=1.
  - On i_adv: slot k <= slot k-1 for k=15..1, slot 0 <= i_new_word, o_round <= o_round+1.
  - Without i_adv: hold everything.
  - i_blk_valid is ignored.
- Advance on o_round==ROUNDS-1 -> DONE. o_round stays at ROUNDS-1 (no wrap to 0 observable in RUN). The window still shifts on this advance.
- DONE: o_done=1 for exactly one cycle, o_busy=0, o_blk_ready=0, i_adv ignored. Window and o_round hold. Next state is IDLE.
- Back-to-back blocks: minimum spacing is load, ROUNDS advances, 1 DONE cycle, then IDLE accepts.
- Operand mapping during round t (consumer contract):
  - slot 1 = W_{t+14} (sigma1 input)
  - slot 6 = W_{t+9}
  - slot 14 = W_{t+1} (sigma0 input)
  - slot 15 = W_t
- Arithmetic: i_new_word = sigma1(slot1) + slot6 + sigma0(slot14) + slot15 mod 2^32, combinational from o_words within the same cycle.
- Words shifted in during rounds 48..63 are never consumed; their values are don't-care but still latched.
- o_words, o_wt and o_round are registered outputs with zero combinational path from i_adv.
- Reset (i_rst_n=0 at a clock edge), in any state including mid-RUN:
  - state -> IDLE
  - window all zero, o_wt=0, o_round=0
  - o_busy=0, o_done=0, o_blk_ready=1 from the first cycle after the reset edge
  - A block in flight is discarded.
- Simultaneous i_blk_valid and i_adv in IDLE: the load wins and i_adv is ignored.

Optional Feature:
SHA_SCHED_INTERNAL_EN
- Defined:
  - The block computes sigma0 (ROTR7^ROTR18^SHR3), sigma1 (ROTR17^ROTR19^SHR10) and the 4-operand mod-2^32 sum internally.
  - It shifts that result in on i_adv. i_new_word is ignored.
  - Lets the core drop the external word adder.
- Undefined: i_new_word is shifted in as above, and no sigma logic is instantiated.
- Port list is identical in both builds.

Test Plan:
- Reset then idle: after i_rst_n=0 for 2 cycles -> o_blk_ready=1, o_words=0, o_round=0, o_busy=0, o_done=0.
- Load "abc" block (i_blk = 0x61626380 followed by 13 zero words, then 0x00000000, 0x00000018) -> o_wt=0x61626380, slot 0=0x00000018, o_round=0, o_busy=1, o_blk_ready=0.
- Two advances with SHA_SCHED_INTERNAL_EN defined -> slot 1=0x61626380 (W16), slot 0=0x000F0000 (W17), o_wt=0x00000000 (W2), o_round=2.
- External mode: load zero block; drive i_new_word=0xA5A5A5A5 and i_adv for 16 cycles -> all 16 slots 0xA5A5A5A5, o_round=16.
- Full run: 64 advances with i_adv stalled on every odd cycle -> o_done high exactly one cycle after the 64th advance; o_round=63 in DONE; IDLE and o_blk_ready=1 on the next cycle; extra i_adv in DONE has no effect.
- Mid-run reset at o_round=30 -> next cycle IDLE, window zero, o_round=0. A new block with i_blk_valid held high through the reset is accepted on the first edge with i_rst_n=1.
